// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit: pc_sel codes and the default
// update-state code of the control FSM.
package pc_pkg;

   localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
   localparam logic [1:0] PC_SEL_RETURN = 2'b11;

   localparam logic [3:0] UPDATE_STATE_DEFAULT = 4'b1000;

endpackage

// File: rtl/pc_if.sv
// Control/status bundle of the program-counter unit; master drives control,
// slave (pc_unit) returns the PC and RAS status.
interface pc_if #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned IMM_W   = 12,
   parameter int unsigned STATE_W = 4
) ();

   logic [STATE_W-1:0] state;
   logic [1:0]         pc_sel;
   logic               branch_taken;
   logic [IMM_W-1:0]   immediate;
   logic [PC_W-1:0]    target;
   logic               push_ra;
   logic [PC_W-1:0]    pc;
   logic               misalign;
   logic               ras_empty;
   logic               ras_full;
   logic               ras_ovf;
   logic               ras_unf;

   modport master (
      output state, pc_sel, branch_taken, immediate, target, push_ra,
      input  pc, misalign, ras_empty, ras_full, ras_ovf, ras_unf
   );

   modport slave (
      input  state, pc_sel, branch_taken, immediate, target, push_ra,
      output pc, misalign, ras_empty, ras_full, ras_ovf, ras_unf
   );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, swap (push+pop), overwrite-oldest
// on overflow, registered one-cycle overflow/underflow pulses.
module pc_ras #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] link_i,
   output logic [W-1:0] top_o,
   output logic         empty_o,
   output logic         full_o,
   output logic         ovf_o,
   output logic         unf_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] sp_q;
   logic [PTR_W-1:0] top_idx;
   logic [PTR_W:0]   cnt_q;
   logic             ovf_q;
   logic             unf_q;

   assign top_idx = sp_q - 1'b1;
   assign top_o   = mem_q[top_idx];
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
   assign ovf_o   = ovf_q;
   assign unf_o   = unf_q;

   // Storage needs no reset: a zero count makes every entry unreachable.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (push_i && pop_i && !empty_o)
            mem_q[top_idx] <= link_i;
         else if (push_i && !(pop_i && !empty_o))
            mem_q[sp_q] <= link_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= 1'b0;
         unf_q <= pop_i && empty_o;
         if (pop_i && !empty_o) begin
            if (!push_i) begin
               sp_q  <= top_idx;
               cnt_q <= cnt_q - 1'b1;
            end
         end else if (push_i) begin
            sp_q <= sp_q + 1'b1;
            if (full_o) ovf_q <= 1'b1;
            else        cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: sequential / branch / jump / return update once per
// instruction. Define PC_RAS_EN to build the return-address stack.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned         PC_W         = 32,
   parameter int unsigned         IMM_W        = 12,
   parameter int unsigned         STATE_W      = 4,
   parameter logic [STATE_W-1:0]  UPDATE_STATE = STATE_W'(UPDATE_STATE_DEFAULT),
   parameter bit                  WORD_ADDR    = 1'b1,
   parameter logic [PC_W-1:0]     RESET_PC     = '0,
   parameter int unsigned         RAS_DEPTH    = 4
) (
   input logic clk,
   input logic rst_n,
   pc_if.slave bus
);

   localparam logic [PC_W-1:0] STEP = WORD_ADDR ? PC_W'(1) : PC_W'(4);

   logic                   upd;
   logic [PC_W-1:0]        pc_q, pc_d;
   logic                   misalign_q, misalign_d;
   logic [PC_W-1:0]        seq_pc, br_pc, jmp_pc;
   logic signed [PC_W-1:0] offset, offset_w;
   logic [PC_W-1:0]        ras_top;
   logic                   ras_empty, ras_push, ras_pop;

   assign upd    = (bus.state == UPDATE_STATE);
   assign seq_pc = pc_q + STEP;
   assign offset = {{(PC_W-IMM_W){bus.immediate[IMM_W-1]}}, bus.immediate};
   // Shift kept in its own signed net so the add below cannot demote it to a logical shift.
   assign offset_w = offset >>> 2;
   assign br_pc  = WORD_ADDR ? (pc_q + offset_w) : (pc_q + offset);
   assign jmp_pc = WORD_ADDR ? (bus.target >> 2) : bus.target;

   always_comb begin
      pc_d       = pc_q;
      misalign_d = 1'b0;
      ras_push   = 1'b0;
      ras_pop    = 1'b0;
      if (upd) begin
         pc_d     = seq_pc;
         ras_push = bus.push_ra;
         unique case (bus.pc_sel)
            PC_SEL_BRANCH: begin
               if (bus.branch_taken) begin
                  if (bus.immediate[1:0] != 2'b00) misalign_d = 1'b1;
                  else                             pc_d = br_pc;
               end
            end
            PC_SEL_JUMP: begin
               if (bus.target[1:0] != 2'b00) misalign_d = 1'b1;
               else                          pc_d = jmp_pc;
            end
            PC_SEL_RETURN: begin
               ras_pop = 1'b1;
               if (!ras_empty) pc_d = ras_top;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.misalign = misalign_q;

`ifdef PC_RAS_EN
   pc_ras #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (ras_push),
      .pop_i   (ras_pop),
      .link_i  (seq_pc),
      .top_o   (ras_top),
      .empty_o (ras_empty),
      .full_o  (bus.ras_full),
      .ovf_o   (bus.ras_ovf),
      .unf_o   (bus.ras_unf)
   );
   assign bus.ras_empty = ras_empty;
`else
   localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;
   logic unused_ras;
   assign unused_ras    = ^{ras_push, ras_pop};
   assign ras_top       = '0;
   assign ras_empty     = 1'b1;
   assign bus.ras_empty = 1'b1;
   assign bus.ras_full  = 1'b0;
   assign bus.ras_ovf   = 1'b0;
   assign bus.ras_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a byte-mode instance (RESET_PC=0x40) and a
// word-mode instance, expected observations queued per update and popped after it.
module tb_pc_unit;
   import pc_pkg::*;

`ifdef PC_RAS_EN
   localparam bit RAS = 1'b1;
`else
   localparam bit RAS = 1'b0;
`endif
   localparam logic [3:0] UPD = 4'b1000;

   typedef struct packed {
      logic        w;
      logic        go;
      logic        rst;
      logic [1:0]  sel;
      logic        taken;
      logic [11:0] imm;
      logic [31:0] tgt;
      logic        push;
   } stim_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        mis;
      logic        emp;
      logic        full;
      logic        ovf;
      logic        unf;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];

   always #5 clk = ~clk;

   pc_if #(.PC_W(32), .IMM_W(12), .STATE_W(4)) bb ();
   pc_if #(.PC_W(32), .IMM_W(12), .STATE_W(4)) bw ();

   pc_unit #(.PC_W(32), .IMM_W(12), .STATE_W(4), .UPDATE_STATE(4'b1000),
             .WORD_ADDR(1'b0), .RESET_PC(32'h40), .RAS_DEPTH(4))
      u_byte (.clk(clk), .rst_n(rst_n), .bus(bb));

   pc_unit #(.PC_W(32), .IMM_W(12), .STATE_W(4), .UPDATE_STATE(4'b1000),
             .WORD_ADDR(1'b1), .RESET_PC(32'h0), .RAS_DEPTH(4))
      u_word (.clk(clk), .rst_n(rst_n), .bus(bw));

   function automatic stim_t mk(input logic w, input logic go, input logic rst, input logic [1:0] sel,
                                input logic taken, input logic [11:0] imm, input logic [31:0] tgt,
                                input logic push);
      return '{w, go, rst, sel, taken, imm, tgt, push};
   endfunction

   function automatic obs_t ob(input logic [31:0] pc, input logic mis, input logic emp,
                               input logic full, input logic ovf, input logic unf);
      return '{pc, mis, emp, full, ovf, unf};
   endfunction

   function automatic obs_t observe(input logic w);
      if (w) return '{bw.pc, bw.misalign, bw.ras_empty, bw.ras_full, bw.ras_ovf, bw.ras_unf};
      return '{bb.pc, bb.misalign, bb.ras_empty, bb.ras_full, bb.ras_ovf, bb.ras_unf};
   endfunction

   task automatic drive(input stim_t s);
      rst_n = !s.rst;
      if (s.w) begin
         bw.state = s.go ? UPD : 4'h0; bw.pc_sel = s.sel; bw.branch_taken = s.taken;
         bw.immediate = s.imm; bw.target = s.tgt; bw.push_ra = s.push;
      end else begin
         bb.state = s.go ? UPD : 4'h0; bb.pc_sel = s.sel; bb.branch_taken = s.taken;
         bb.immediate = s.imm; bb.target = s.tgt; bb.push_ra = s.push;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      obs_t got, want;
      rst_n = 1'b0;
      bb.state = UPD; bb.pc_sel = PC_SEL_JUMP; bb.branch_taken = 1'b0;
      bb.immediate = '0; bb.target = 32'h900; bb.push_ra = 1'b1;
      bw.state = UPD; bw.pc_sel = PC_SEL_JUMP; bw.branch_taken = 1'b0;
      bw.immediate = '0; bw.target = 32'h900; bw.push_ra = 1'b1;
      exp_q.push_back(ob(32'h40, 0, 1, 0, 0, 0));
      exp_q.push_back(ob(32'h0, 0, 1, 0, 0, 0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         got = observe(i[0]); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
         end
      end
      bb.state = 4'h0; bw.state = 4'h0; bb.push_ra = 1'b0; bw.push_ra = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_seq();
      stim_t s[$]; obs_t e[$]; obs_t got, want;
      s.push_back(mk(0,1,0,PC_SEL_SEQ,0,0,0,0));    e.push_back(ob(32'h44,0,1,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_SEQ,0,0,0,0));    e.push_back(ob(32'h48,0,1,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_BRANCH,0,12'hFF8,0,0)); e.push_back(ob(32'h4C,0,1,0,0,0));
      s.push_back(mk(0,0,0,PC_SEL_SEQ,0,0,0,0));    e.push_back(ob(32'h4C,0,1,0,0,0));
      for (int i = 0; i < s.size(); i++) begin
         exp_q.push_back(e[i]); drive(s[i]);
         got = observe(s[i].w); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL seq[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_misalign_byte();
      stim_t s[$]; obs_t e[$]; obs_t got, want;
      s.push_back(mk(0,1,0,PC_SEL_JUMP,0,0,32'h100,0));       e.push_back(ob(32'h100,0,1,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_BRANCH,1,12'h006,0,0));     e.push_back(ob(32'h104,1,1,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_JUMP,0,0,32'h200,0));       e.push_back(ob(32'h200,0,1,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_JUMP,0,0,32'h202,0));       e.push_back(ob(32'h204,1,1,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_BRANCH,1,12'hFFC,0,0));     e.push_back(ob(32'h200,0,1,0,0,0));
      s.push_back(mk(0,0,0,PC_SEL_SEQ,0,0,0,0));              e.push_back(ob(32'h200,0,1,0,0,0));
      for (int i = 0; i < s.size(); i++) begin
         exp_q.push_back(e[i]); drive(s[i]);
         got = observe(s[i].w); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL misalign_byte[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_branch_word();
      stim_t s[$]; obs_t e[$]; obs_t got, want;
      s.push_back(mk(1,1,0,PC_SEL_JUMP,0,0,32'd20,0));        e.push_back(ob(32'd5,0,1,0,0,0));
      s.push_back(mk(1,1,0,PC_SEL_BRANCH,1,12'hFF8,0,0));     e.push_back(ob(32'd3,0,1,0,0,0));
      s.push_back(mk(1,1,0,PC_SEL_JUMP,0,0,32'd20,0));        e.push_back(ob(32'd5,0,1,0,0,0));
      s.push_back(mk(1,1,0,PC_SEL_BRANCH,0,12'hFF8,0,0));     e.push_back(ob(32'd6,0,1,0,0,0));
      s.push_back(mk(1,1,0,PC_SEL_BRANCH,1,12'h006,0,0));     e.push_back(ob(32'd7,1,1,0,0,0));
      s.push_back(mk(1,1,0,PC_SEL_JUMP,0,0,32'h13,0));        e.push_back(ob(32'd8,1,1,0,0,0));
      s.push_back(mk(1,1,0,PC_SEL_JUMP,0,0,32'h400,0));       e.push_back(ob(32'h100,0,1,0,0,0));
      s.push_back(mk(1,0,0,PC_SEL_SEQ,0,0,0,0));              e.push_back(ob(32'h100,0,1,0,0,0));
      for (int i = 0; i < s.size(); i++) begin
         exp_q.push_back(e[i]); drive(s[i]);
         got = observe(s[i].w); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL branch_word[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_wrap_word();
      stim_t s[$]; obs_t e[$]; obs_t got, want;
      s.push_back(mk(1,1,0,PC_SEL_JUMP,0,0,32'h0,0));         e.push_back(ob(32'h0,0,1,0,0,0));
      s.push_back(mk(1,1,0,PC_SEL_BRANCH,1,12'hFFC,0,0));     e.push_back(ob(32'hFFFF_FFFF,0,1,0,0,0));
      s.push_back(mk(1,1,0,PC_SEL_SEQ,0,0,0,0));              e.push_back(ob(32'h0,0,1,0,0,0));
      s.push_back(mk(1,1,0,PC_SEL_RETURN,0,0,0,0));           e.push_back(ob(32'h1,0,1,0,0,RAS));
      s.push_back(mk(1,0,0,PC_SEL_SEQ,0,0,0,0));              e.push_back(ob(32'h1,0,1,0,0,0));
      for (int i = 0; i < s.size(); i++) begin
         exp_q.push_back(e[i]); drive(s[i]);
         got = observe(s[i].w); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL wrap_word[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_back_to_back_ras();
      stim_t s[$]; obs_t e[$]; obs_t got, want;
      s.push_back(mk(0,1,0,PC_SEL_JUMP,0,0,32'h10,0));  e.push_back(ob(32'h10,0,1,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_JUMP,0,0,32'h20,1));  e.push_back(ob(32'h20,0,!RAS,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_JUMP,0,0,32'h30,1));  e.push_back(ob(32'h30,0,!RAS,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_JUMP,0,0,32'h40,1));  e.push_back(ob(32'h40,0,!RAS,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_JUMP,0,0,32'h50,1));  e.push_back(ob(32'h50,0,!RAS,RAS,0,0));
      s.push_back(mk(0,1,0,PC_SEL_JUMP,0,0,32'h60,1));  e.push_back(ob(32'h60,0,!RAS,RAS,RAS,0));
      s.push_back(mk(0,1,0,PC_SEL_RETURN,0,0,0,0));     e.push_back(ob(RAS ? 32'h54 : 32'h64,0,!RAS,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_RETURN,0,0,0,0));     e.push_back(ob(RAS ? 32'h44 : 32'h68,0,!RAS,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_RETURN,0,0,0,0));     e.push_back(ob(RAS ? 32'h34 : 32'h6C,0,!RAS,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_RETURN,0,0,0,0));     e.push_back(ob(RAS ? 32'h24 : 32'h70,0,1,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_RETURN,0,0,0,0));     e.push_back(ob(RAS ? 32'h28 : 32'h74,0,1,0,0,RAS));
      s.push_back(mk(0,0,0,PC_SEL_SEQ,0,0,0,0));        e.push_back(ob(RAS ? 32'h28 : 32'h74,0,1,0,0,0));
      for (int i = 0; i < s.size(); i++) begin
         exp_q.push_back(e[i]); drive(s[i]);
         got = observe(s[i].w); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL ras[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_swap();
      stim_t s[$]; obs_t e[$]; obs_t got, want;
      s.push_back(mk(0,1,0,PC_SEL_JUMP,0,0,32'h7C,0));   e.push_back(ob(32'h7C,0,1,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_JUMP,0,0,32'h300,1));  e.push_back(ob(32'h300,0,!RAS,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_RETURN,0,0,0,1));      e.push_back(ob(RAS ? 32'h80 : 32'h304,0,!RAS,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_RETURN,0,0,0,0));      e.push_back(ob(RAS ? 32'h304 : 32'h308,0,1,0,0,0));
      s.push_back(mk(0,0,0,PC_SEL_SEQ,0,0,0,0));         e.push_back(ob(RAS ? 32'h304 : 32'h308,0,1,0,0,0));
      for (int i = 0; i < s.size(); i++) begin
         exp_q.push_back(e[i]); drive(s[i]);
         got = observe(s[i].w); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL swap[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t s[$]; obs_t e[$]; obs_t got, want;
      s.push_back(mk(0,1,0,PC_SEL_JUMP,0,0,32'h500,1));  e.push_back(ob(32'h500,0,!RAS,0,0,0));
      s.push_back(mk(0,1,1,PC_SEL_JUMP,0,0,32'h900,1));  e.push_back(ob(32'h40,0,1,0,0,0));
      s.push_back(mk(0,1,0,PC_SEL_RETURN,0,0,0,0));      e.push_back(ob(32'h44,0,1,0,0,RAS));
      s.push_back(mk(0,0,0,PC_SEL_SEQ,0,0,0,0));         e.push_back(ob(32'h44,0,1,0,0,0));
      for (int i = 0; i < s.size(); i++) begin
         exp_q.push_back(e[i]); drive(s[i]);
         got = observe(s[i].w); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL reset_mid[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   initial begin
      bb.state = 4'h0; bb.pc_sel = PC_SEL_SEQ; bb.branch_taken = 1'b0;
      bb.immediate = '0; bb.target = '0; bb.push_ra = 1'b0;
      bw.state = 4'h0; bw.pc_sel = PC_SEL_SEQ; bw.branch_taken = 1'b0;
      bw.immediate = '0; bw.target = '0; bw.push_ra = 1'b0;
      test_reset();
      test_seq();
      test_misalign_byte();
      test_branch_word();
      test_wrap_word();
      test_back_to_back_ras();
      test_swap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
